// File: rtl/prog_stream_receiver_if.sv
// Payload word stream from the programming-stream receiver to a config sink.
// This is a valid/ready handshake: a word transfers when out_valid && out_ready.
interface prog_stream_receiver_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/prog_stream_receiver.sv
// Deserialises the SoC programming stream (head sampled on programming_clock falling edges).
// It frames sync/length/payload/checksum and hands payload words to a 2-entry FIFO.
module prog_stream_receiver #(
    parameter int               WORD_W    = 16,
    parameter logic [WORD_W-1:0] SYNC_WORD = 16'hA55A,
    parameter int               LEN_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    programming_clock,
    input  logic                    head,
    prog_stream_receiver_if.master  stream,
    output logic                    frame_done,
    output logic                    crc_err,
    output logic                    overflow,
    output logic                    busy
);
    localparam int BW = $clog2(WORD_W);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CHK     = 2'd3;

    logic [1:0]        pclk_s, head_s;
    logic              pclk_prev;
    logic [1:0]        state;
    logic [WORD_W-1:0] sh, sh_nxt, xacc;
    logic [BW-1:0]     bcnt;
    logic [LEN_W-1:0]  wcnt, wcnt_inc, len;
    logic              bit_ev, word_end, sync_hit, push, pop, push_ok;
    logic [1:0][WORD_W-1:0] mem;
    logic              rd_ptr, wr_ptr;
    logic [1:0]        cnt;

    // Equal-depth synchronisers keep head aligned with the pclk edge it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pclk_s    <= '0;
            head_s    <= '0;
            pclk_prev <= 1'b0;
        end else begin
            pclk_s    <= {pclk_s[0], programming_clock};
            head_s    <= {head_s[0], head};
            pclk_prev <= pclk_s[1];
        end
    end

    assign bit_ev   = pclk_prev & ~pclk_s[1];
    assign sh_nxt   = {sh[WORD_W-2:0], head_s[1]};
    assign word_end = bit_ev && (bcnt == BW'(WORD_W - 1));
    assign wcnt_inc = wcnt + 1'b1;
    assign sync_hit = en && bit_ev && (state == ST_HUNT) && (sh_nxt == SYNC_WORD);
    assign push     = en && word_end && (state == ST_PAYLOAD);
    assign busy     = (state != ST_HUNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_HUNT;
            sh         <= '0;
            bcnt       <= '0;
            wcnt       <= '0;
            len        <= '0;
            xacc       <= '0;
            frame_done <= 1'b0;
            crc_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                state <= ST_HUNT;
                sh    <= '0;
                bcnt  <= '0;
                wcnt  <= '0;
                len   <= '0;
                xacc  <= '0;
            end else if (bit_ev) begin
                sh <= sh_nxt;
                if (state == ST_HUNT) begin
                    if (sync_hit) begin
                        state   <= ST_LEN;
                        bcnt    <= '0;
                        xacc    <= '0;
                        crc_err <= 1'b0;
                    end
                end else begin
                    bcnt <= word_end ? '0 : bcnt + 1'b1;
                    if (word_end) begin
                        if (state == ST_LEN) begin
                            len   <= sh_nxt[LEN_W-1:0];
                            wcnt  <= '0;
                            state <= (sh_nxt[LEN_W-1:0] == '0) ? ST_CHK : ST_PAYLOAD;
                        end else if (state == ST_PAYLOAD) begin
                            // Dropped words still count so the frame stays aligned.
                            xacc <= xacc ^ sh_nxt;
                            wcnt <= wcnt_inc;
                            if (wcnt_inc == len) state <= ST_CHK;
                        end else begin
                            frame_done <= 1'b1;
                            if (sh_nxt != xacc) crc_err <= 1'b1;
                            state <= ST_HUNT;
                        end
                    end
                end
            end
        end
    end

    assign stream.out_valid = (cnt != 2'd0);
    assign stream.out_data  = stream.out_valid ? mem[rd_ptr] : '0;
    assign pop              = stream.out_valid && stream.out_ready;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign push_ok          = push && ((cnt != 2'd2) || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem      <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (!en) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (sync_hit) overflow <= 1'b0;
            if (pop) rd_ptr <= ~rd_ptr;
            if (push_ok) begin
                mem[wr_ptr] <= sh_nxt;
                wr_ptr      <= ~wr_ptr;
            end else if (push) begin
                overflow <= 1'b1;
            end
            cnt <= cnt + {1'b0, push_ok} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_prog_stream_receiver.sv
// Directed bench for prog_stream_receiver: framing, checksum, FIFO stall/drop, enable and reset.
module tb_prog_stream_receiver;
    logic clk = 1'b0;
    logic rst, en, pclk, head;
    logic frame_done, crc_err, overflow, busy;
    int   n_chk = 0, n_pass = 0;
    int   fd_cnt = 0;
    int   fd_base, q_base;
    logic [15:0] rxq[$];

    prog_stream_receiver_if #(.WORD_W(16)) bus ();

    prog_stream_receiver #(.WORD_W(16), .SYNC_WORD(16'hA55A), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .programming_clock(pclk), .head(head),
        .stream(bus), .frame_done(frame_done), .crc_err(crc_err),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && frame_done) fd_cnt++;
        if (rst && bus.out_valid && bus.out_ready) rxq.push_back(bus.out_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        pclk = 1'b1;
        head = b;
        cycles(4);
        pclk = 1'b0;
        cycles(4);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; pclk = 1'b0; head = 1'b0;
        bus.out_ready = 1'b1;
        cycles(3);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_crc", crc_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        cycles(3);

        // Reset in the middle of a payload word
        fd_base = fd_cnt;
        send_word(16'hA55A); send_word(16'h0003); send_word(16'h1111);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("t1_busy_mid", busy, 1);
        chk("t1_first_word", rxq.size(), 1);
        rst = 1'b0;
        #1;
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_valid", bus.out_valid, 0);
        chk("t1_rst_data", bus.out_data, 0);
        chk("t1_rst_ovf", overflow, 0);
        cycles(2);
        rst = 1'b1;
        cycles(2);
        chk("t1_no_done", fd_cnt, fd_base);
        rxq.delete();

        // Good frame
        fd_base = fd_cnt;
        send_word(16'hA55A); send_word(16'h0003);
        send_word(16'h1111); send_word(16'h2222); send_word(16'h3333); send_word(16'h0000);
        chk("t2_count", rxq.size(), 3);
        chk("t2_w0", rxq[0], 16'h1111);
        chk("t2_w1", rxq[1], 16'h2222);
        chk("t2_w2", rxq[2], 16'h3333);
        chk("t2_done", fd_cnt, fd_base + 1);
        chk("t2_crc", crc_err, 0);
        chk("t2_busy", busy, 0);

        // Bad checksum
        fd_base = fd_cnt; q_base = rxq.size();
        send_word(16'hA55A); send_word(16'h0003);
        send_word(16'h1111); send_word(16'h2222); send_word(16'h3333); send_word(16'h0001);
        chk("t3_count", rxq.size(), q_base + 3);
        chk("t3_done", fd_cnt, fd_base + 1);
        chk("t3_crc", crc_err, 1);

        // Garbage then zero-length frame
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        chk("t4_crc_sticky", crc_err, 1);
        send_word(16'hA55A);
        chk("t4_crc_clr", crc_err, 0);
        chk("t4_busy", busy, 1);
        fd_base = fd_cnt; q_base = rxq.size();
        send_word(16'h0000); send_word(16'h0000);
        chk("t4_done", fd_cnt, fd_base + 1);
        chk("t4_crc", crc_err, 0);
        chk("t4_no_out", rxq.size(), q_base);
        chk("t4_busy_end", busy, 0);

        // Stalled sink: two words held, two dropped
        bus.out_ready = 1'b0;
        fd_base = fd_cnt; q_base = rxq.size();
        send_word(16'hA55A); send_word(16'h0004);
        send_word(16'h1234); send_word(16'h5678);
        chk("t5_valid", bus.out_valid, 1);
        chk("t5_hold_a", bus.out_data, 16'h1234);
        chk("t5_no_ovf", overflow, 0);
        send_word(16'h9ABC);
        chk("t5_ovf", overflow, 1);
        send_word(16'hDEF0);
        chk("t5_hold_b", bus.out_data, 16'h1234);
        send_word(16'h0000);
        chk("t5_done", fd_cnt, fd_base + 1);
        chk("t5_crc", crc_err, 0);
        chk("t5_none_yet", rxq.size(), q_base);
        bus.out_ready = 1'b1;
        cycles(6);
        chk("t5_popped", rxq.size(), q_base + 2);
        chk("t5_p0", rxq[q_base], 16'h1234);
        chk("t5_p1", rxq[q_base + 1], 16'h5678);
        chk("t5_empty", bus.out_valid, 0);
        chk("t5_ovf_sticky", overflow, 1);

        // Enable dropped mid-payload
        fd_base = fd_cnt;
        send_word(16'hA55A);
        chk("t6_ovf_clr", overflow, 0);
        send_word(16'h0003); send_word(16'h1111);
        for (int i = 7; i >= 0; i--) send_bit(1'(16'h2222 >> (i + 8)));
        q_base = rxq.size();
        en = 1'b0;
        cycles(10);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_busy", busy, 0);
        en = 1'b1;
        for (int i = 7; i >= 0; i--) send_bit(1'(16'h2222 >> i));
        send_word(16'h3333); send_word(16'h0000);
        chk("t6_no_out", rxq.size(), q_base);
        chk("t6_no_done", fd_cnt, fd_base);
        chk("t6_idle", busy, 0);
        send_word(16'hA55A); send_word(16'h0001); send_word(16'h4321); send_word(16'h4321);
        chk("t6_new_count", rxq.size(), q_base + 1);
        chk("t6_new_word", rxq[q_base], 16'h4321);
        chk("t6_new_done", fd_cnt, fd_base + 1);
        chk("t6_new_crc", crc_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
